serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle, bit-serial two's-complement subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
//  Complements the combinational ripple adder path by providing area-cheap subtraction for
//  datapaths that tolerate latency. Uses a start/busy/done handshake with a single borrow flip-flop.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  A      in   WIDTH  minuend, captured on accepted start
//  B      in   WIDTH  subtrahend, captured on accepted start
//  Bin    in   1      borrow-in, captured on accepted start
//  busy   out  1      high in RUN and DONE
//  done   out  1      one-cycle pulse, result valid
//  Diff   out  WIDTH  difference, held until next accepted start
//  Bout   out  1      borrow-out (1 => unsigned A < B+Bin), held with Diff
//  ovf    out  1      signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, Diff=0, Bout=0, ovf=0; bit counter=0; borrow FF=0.
//  - FSM: IDLE -(start)-> RUN -(WIDTH bits done)-> DONE -(always)-> IDLE.
//  - Accept: start high at the edge ending cycle t in IDLE latches A, B into shift regs; borrow FF<=Bin.
//  - RUN: cycles t+1 .. t+WIDTH; in cycle t+1+i bit i computed:
//      d_i = a_i ^ b_i ^ br;  br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
//    d_i shifted into Diff from MSB side; br' registered. Counter increments; leaves RUN after bit WIDTH-1.
//  - DONE: cycle t+WIDTH+1; done=1, Diff complete, Bout=final borrow. Latency start->done = WIDTH+1 cycles.
//  - Diff/Bout(/ovf) are updated only on the transition into DONE; stable from then until the next accepted start.
//    During RUN, Diff holds partial shift contents, which are not valid.
//  - start while RUN or DONE: ignored, no queueing. start in the IDLE cycle after DONE: accepted
//    (back-to-back throughput = one op per WIDTH+2 cycles).
//  - Inputs A/B/Bin may change freely after acceptance; only captured values are used.
//  - rst in any state (incl. mid-RUN): abort, return to reset values next edge; no done pulse.
//  - Wrap-around: result is modulo 2^WIDTH; e.g. 0 - 1 = all-ones with Bout=1.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined: port ovf exists; ovf = (A[MSB]^B[MSB]) & (A[MSB]^Diff[MSB]),
//    registered with Diff on entry to DONE, reset 0, held like Diff.
//  Not defined: no ovf port and no related logic; all other behaviour identical.
// STRUCTURE
//  Package serial_sub_pkg: typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sub_state_t;
//    function clog2-based counter width helper.
//  Sub-module full_subtractor (a, b, bin -> d, bout), pure combinational, one instance for the serial bit slice.
//  Top holds FSM, counter, shift registers, borrow FF, output registers.
// TESTING (WIDTH=8 unless noted)
//  A=0x05,B=0x03,Bin=0 -> done exactly 9 cycles after start; Diff=0x02, Bout=0.
//  A=0x03,B=0x05,Bin=0 -> Diff=0xFE, Bout=1; A=0x00,B=0x00,Bin=1 -> Diff=0xFF, Bout=1.
//  start held high through RUN/DONE with changing A/B -> single done; result matches first captured operands; next op starts in following IDLE.
//  rst asserted at 4th RUN cycle -> next cycle busy=0, Diff=0, Bout=0; no done pulse; new op then correct.
//  Back-to-back: two ops, start held high continuously -> done pulses 10 cycles apart; results held between.
//  With SERIAL_SUB_OVF_EN: A=0x80,B=0x01 -> Diff=0x7F, ovf=1; A=0x7F,B=0x01 -> Diff=0x7E, ovf=0.
//  Random: 1000 ops vs reference model A-B-Bin over WIDTH=4,8,16.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and helpers for the bit-serial subtractor
//
// Purpose : FSM state encoding and the bit-counter width helper used by
//           serial_subtractor.
// Ports   : none (package).

package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sub_state_t;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice;
    // never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor
//
// Purpose : d = a - b - bin for a single bit, with borrow out.
// Ports   : a    in  1  minuend bit
//           b    in  1  subtrahend bit
//           bin  in  1  borrow in
//           d    out 1  difference bit
//           bout out 1  borrow out

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when the minuend bit is smaller, or when the bits are equal
    // and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first
//
// Purpose : Diff = A - B - Bin computed one bit per clock with a single borrow
//           flip-flop. start/busy/done handshake; latency start->done is
//           WIDTH+1 cycles, back-to-back throughput one op per WIDTH+2 cycles.
// Macro   : SERIAL_SUB_OVF_EN adds the ovf output (signed overflow).
// Ports   : clk   in  1      rising-edge clock
//           rst   in  1      synchronous active-high reset
//           start in  1      request, sampled only in IDLE
//           A     in  WIDTH  minuend, captured on accepted start
//           B     in  WIDTH  subtrahend, captured on accepted start
//           Bin   in  1      borrow in, captured on accepted start
//           busy  out 1      high in RUN and DONE
//           done  out 1      one-cycle pulse, result valid
//           Diff  out WIDTH  difference, held until next accepted start
//           Bout  out 1      borrow out, held with Diff
//           ovf   out 1      signed overflow (SERIAL_SUB_OVF_EN only)

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    sub_state_t       r_state;
    sub_state_t       w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic             w_d;
    logic             w_bout;
    logic             w_last_bit;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out of the shift registers, so they are
    // kept separately for the overflow term.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;
`endif

    assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

    full_subtractor u_bit_slice (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)      w_next_state = S_RUN;
            S_RUN:   if (w_last_bit) w_next_state = S_DONE;
            S_DONE:                  w_next_state = S_IDLE;
            default:                 w_next_state = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: operand capture, bit-serial shift, result registers.
    // The difference is shifted straight into the output register from the
    // MSB side, so after WIDTH shifts bit 0 sits at Diff[0]; its contents are
    // only meaningful once done has been seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_diff <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr <= A;
                        r_b_sr <= B;
                        r_br   <= Bin;
                        r_cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_br   <= w_bout;
                    r_cnt  <= r_cnt + 1'b1;
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    if (w_last_bit) begin
                        r_bout <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                        // w_d is the result sign bit on the final step.
                        r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign Diff = r_diff;
    assign Bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH 4/8/16)

module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index 0 -> WIDTH 4, 1 -> WIDTH 8, 2 -> WIDTH 16
    logic        start_v [3];
    logic [15:0] a_v     [3];
    logic [15:0] b_v     [3];
    logic        bin_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [15:0] diff_v  [3];
    logic        bout_v  [3];
    logic        ovf_v   [3];

    logic        busy4, busy8, busy16;
    logic        done4, done8, done16;
    logic [3:0]  diff4;
    logic [7:0]  diff8;
    logic [15:0] diff16;
    logic        bout4, bout8, bout16;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf4, ovf8, ovf16;
`endif

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .A(a_v[0][3:0]), .B(b_v[0][3:0]), .Bin(bin_v[0]),
        .busy(busy4), .done(done4), .Diff(diff4), .Bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .A(a_v[1][7:0]), .B(b_v[1][7:0]), .Bin(bin_v[1]),
        .busy(busy8), .done(done8), .Diff(diff8), .Bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .A(a_v[2]), .B(b_v[2]), .Bin(bin_v[2]),
        .busy(busy16), .done(done16), .Diff(diff16), .Bout(bout16)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf16)
`endif
    );

    always_comb begin
        busy_v[0] = busy4;  busy_v[1] = busy8;  busy_v[2] = busy16;
        done_v[0] = done4;  done_v[1] = done8;  done_v[2] = done16;
        diff_v[0] = {12'h0, diff4};
        diff_v[1] = {8'h0, diff8};
        diff_v[2] = diff16;
        bout_v[0] = bout4;  bout_v[1] = bout8;  bout_v[2] = bout16;
`ifdef SERIAL_SUB_OVF_EN
        ovf_v[0] = ovf4;    ovf_v[1] = ovf8;    ovf_v[2] = ovf16;
`else
        ovf_v[0] = 1'b0;    ovf_v[1] = 1'b0;    ovf_v[2] = 1'b0;
`endif
    end

    int checks = 0;
    int errors = 0;

    function automatic int width_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 8 : 16;
    endfunction

    // Reference: plain integer arithmetic on the operands.
    function automatic void ref_sub(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic bin, output logic [15:0] d,
                                    output logic bo, output logic ov);
        longint m  = longint'(1) << w;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint r  = ua - ub - longint'(bin);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint sr = sa - sb - longint'(bin);
        d  = 16'(((r % m) + m) % m);
        bo = (r < 0);
        ov = (sr < -(m / 2)) || (sr > (m / 2 - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: request one op, wait for done.
    // lat = number of rising edges from the accepting edge's cycle to done.
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, output int lat);
        a_v[k] = a; b_v[k] = b; bin_v[k] = bin; start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        lat = 1;
        while (!done_v[k] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int k, input logic [15:0] a,
                                input logic [15:0] b, input logic bin);
        logic [15:0] ed;
        logic        eb, eo;
        ref_sub(width_of(k), a, b, bin, ed, eb, eo);
        chk({tag, "_done"}, 32'(done_v[k]), 32'd1);
        chk({tag, "_diff"}, 32'(diff_v[k]), 32'(ed));
        chk({tag, "_bout"}, 32'(bout_v[k]), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf_v[k]), 32'(eo));
`endif
    endtask

    initial begin
        int          lat;
        int          gap;
        int          dones;
        logic [15:0] mask;
        logic [15:0] ra, rb;
        logic        rbin;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; bin_v[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", 32'(busy_v[k]), 32'd0);
            chk("rst_done", 32'(done_v[k]), 32'd0);
            chk("rst_diff", 32'(diff_v[k]), 32'd0);
            chk("rst_bout", 32'(bout_v[k]), 32'd0);
            chk("rst_ovf",  32'(ovf_v[k]),  32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed WIDTH=8 operations
        run_op(1, 16'h05, 16'h03, 1'b0, lat);
        chk("lat_5m3", 32'(lat), 32'd9);
        chk("diff_5m3", 32'(diff_v[1]), 32'h02);
        chk("bout_5m3", 32'(bout_v[1]), 32'd0);
        @(negedge clk);
        chk("pulse_done", 32'(done_v[1]), 32'd0);
        chk("pulse_busy", 32'(busy_v[1]), 32'd0);

        run_op(1, 16'h03, 16'h05, 1'b0, lat);
        chk("diff_3m5", 32'(diff_v[1]), 32'hFE);
        chk("bout_3m5", 32'(bout_v[1]), 32'd1);
        @(negedge clk);

        run_op(1, 16'h00, 16'h00, 1'b1, lat);
        chk("diff_0m0b", 32'(diff_v[1]), 32'hFF);
        chk("bout_0m0b", 32'(bout_v[1]), 32'd1);
        @(negedge clk);
        chk("hold_idle_diff", 32'(diff_v[1]), 32'hFF);

        // start held high, operands churning; two back-to-back ops
        a_v[1] = 16'h5A; b_v[1] = 16'h21; bin_v[1] = 1'b0; start_v[1] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!done_v[1]) begin
                a_v[1] = 16'($urandom_range(0, 255));
                b_v[1] = 16'($urandom_range(0, 255));
                bin_v[1] = 1'($urandom_range(0, 1));
            end
        end while (!done_v[1] && lat < 64);
        chk("held_lat", 32'(lat), 32'd9);
        chk("held_diff", 32'(diff_v[1]), 32'h39);
        chk("held_bout", 32'(bout_v[1]), 32'd0);
        a_v[1] = 16'h10; b_v[1] = 16'h20; bin_v[1] = 1'b0;
        @(negedge clk);
        chk("b2b_idle_done", 32'(done_v[1]), 32'd0);
        chk("b2b_idle_busy", 32'(busy_v[1]), 32'd0);
        chk("b2b_held_diff", 32'(diff_v[1]), 32'h39);
        gap = 1;
        do begin
            @(negedge clk);
            gap++;
            if (!done_v[1]) begin
                a_v[1] = 16'($urandom_range(0, 255));
                b_v[1] = 16'($urandom_range(0, 255));
            end
        end while (!done_v[1] && gap < 64);
        start_v[1] = 1'b0;
        chk("b2b_gap", 32'(gap), 32'd10);
        chk("b2b_diff", 32'(diff_v[1]), 32'hF0);
        chk("b2b_bout", 32'(bout_v[1]), 32'd1);
        @(negedge clk);

        // Reset during the 4th RUN cycle
        a_v[1] = 16'h77; b_v[1] = 16'h11; bin_v[1] = 1'b0; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        chk("run_busy", 32'(busy_v[1]), 32'd1);
        chk("run_done", 32'(done_v[1]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy_v[1]), 32'd0);
        chk("abort_diff", 32'(diff_v[1]), 32'd0);
        chk("abort_bout", 32'(bout_v[1]), 32'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[1]) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);

        run_op(1, 16'h80, 16'h01, 1'b0, lat);
        chk("diff_80m1", 32'(diff_v[1]), 32'h7F);
        chk("bout_80m1", 32'(bout_v[1]), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_80m1", 32'(ovf_v[1]), 32'd1);
`endif
        @(negedge clk);
        run_op(1, 16'h7F, 16'h01, 1'b0, lat);
        chk("diff_7Fm1", 32'(diff_v[1]), 32'h7E);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_7Fm1", 32'(ovf_v[1]), 32'd0);
`endif
        @(negedge clk);

        // Random operations across all three widths
        for (int n = 0; n < 1000; n++) begin
            int k;
            k    = n % 3;
            mask = 16'((32'h1 << width_of(k)) - 1);
            ra   = 16'($urandom) & mask;
            rb   = 16'($urandom) & mask;
            rbin = 1'($urandom_range(0, 1));
            run_op(k, ra, rb, rbin, lat);
            chk("rnd_lat", 32'(lat), 32'(width_of(k) + 1));
            check_result("rnd", k, ra, rb, rbin);
            @(negedge clk);
            chk("rnd_idle_busy", 32'(busy_v[k]), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
